// File: rtl/iic_multi_init.sv
// I2C register-init sequencer: walks one ROM table per channel, with optional read-back verify/retry, ms delays and bus timeouts.
// Latency: 4 cycles reset->first iic_trig and between entries; waits on the driver's busy fall, never triggers while busy=1.
`timescale 1ns/1ps
module iic_multi_init #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int NUM_CH    = 2,
    parameter int TBL_DEPTH = 256,
    parameter int VERIFY    = 0,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 2_000_000,
    localparam int AW = $clog2(NUM_CH * TBL_DEPTH),
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              reinit,
    output logic [AW-1:0]     tbl_addr,
    input  logic [31:0]       tbl_data,
    output logic [CW-1:0]     ch_sel,
    output logic [7:0]        device_id,
    output logic              iic_trig,
    output logic              w_r,
    output logic [15:0]       addr,
    output logic [7:0]        data_in,
    input  logic              busy,
    input  logic [7:0]        data_out,
    input  logic              byte_over,
    output logic [NUM_CH-1:0] init_over,
    output logic [NUM_CH-1:0] init_err,
    output logic              all_done
);

    localparam int TICK = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
    localparam int IW   = (TBL_DEPTH > 1) ? $clog2(TBL_DEPTH) : 1;
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, WR_TRIG, WR_WAIT, RD_TRIG, RD_WAIT, CHECK, DELAY, NEXT_CH, DONE
    } state_t;

    state_t        state;
    logic          fetch_ph;
    logic [CW-1:0] ch;
    logic [IW-1:0] idx;
    logic [RW-1:0] retry;
    logic [TW-1:0] tmo_cnt;
    logic [31:0]   dly_cnt;
    logic [31:0]   dly_tgt;
    logic          seen_busy;
    logic [7:0]    rd_data;

    logic idx_last;
    logic ch_last;
    logic bus_done;
    logic tmo_hit;

    assign ch_sel   = ch;
    assign idx_last = (idx == IW'(TBL_DEPTH - 1));
    assign ch_last  = (ch == CW'(NUM_CH - 1));
    assign bus_done = seen_busy && !busy;
    assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            fetch_ph  <= 1'b0;
            ch        <= '0;
            idx       <= '0;
            retry     <= '0;
            tmo_cnt   <= '0;
            dly_cnt   <= '0;
            dly_tgt   <= '0;
            seen_busy <= 1'b0;
            rd_data   <= '0;
            tbl_addr  <= '0;
            device_id <= '0;
            iic_trig  <= 1'b0;
            w_r       <= 1'b1;
            addr      <= '0;
            data_in   <= '0;
            init_over <= '0;
            init_err  <= '0;
            all_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ch    <= '0;
                    idx   <= '0;
                    retry <= '0;
                    state <= FETCH;
                end
                // First phase presents the address, second phase covers the ROM read latency.
                FETCH: begin
                    fetch_ph <= ~fetch_ph;
                    if (!fetch_ph) tbl_addr <= AW'(int'(ch) * TBL_DEPTH + int'(idx));
                    else           state    <= DECODE;
                end
                DECODE: begin
                    if (tbl_data[31:24] == 8'hFF) begin
                        init_over[ch] <= 1'b1;
                        state         <= NEXT_CH;
                    end else if (tbl_data[31:24] == 8'hFE) begin
                        dly_cnt <= '0;
                        dly_tgt <= {24'd0, tbl_data[7:0]} * 32'(TICK);
                        if (tbl_data[7:0] != 8'd0) begin
                            state <= DELAY;
                        end else begin
                            idx   <= idx + 1'b1;
                            retry <= '0;
                            state <= idx_last ? NEXT_CH : FETCH;
                        end
                    end else begin
                        device_id <= tbl_data[31:24];
                        addr      <= tbl_data[23:8];
                        data_in   <= tbl_data[7:0];
                        w_r       <= 1'b1;
                        iic_trig  <= ~busy;
                        tmo_cnt   <= '0;
                        seen_busy <= 1'b0;
                        state     <= WR_TRIG;
                    end
                end
                WR_TRIG, RD_TRIG: begin
                    tmo_cnt   <= '0;
                    seen_busy <= 1'b0;
                    if (iic_trig) begin
                        iic_trig <= 1'b0;
                        state    <= (state == WR_TRIG) ? WR_WAIT : RD_WAIT;
                    end else if (!busy) begin
                        iic_trig <= 1'b1;
                    end
                end
                // Completion is tested before the timeout so a late finish still counts.
                WR_WAIT: begin
                    if (busy) seen_busy <= 1'b1;
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (bus_done) begin
                        if (VERIFY != 0) begin
                            w_r       <= 1'b0;
                            iic_trig  <= 1'b1;
                            tmo_cnt   <= '0;
                            seen_busy <= 1'b0;
                            state     <= RD_TRIG;
                        end else begin
                            idx   <= idx + 1'b1;
                            retry <= '0;
                            state <= idx_last ? NEXT_CH : FETCH;
                        end
                    end else if (tmo_hit) begin
                        init_err[ch] <= 1'b1;
                        state        <= NEXT_CH;
                    end
                end
                RD_WAIT: begin
                    if (busy) seen_busy <= 1'b1;
                    if (byte_over) rd_data <= data_out;
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (bus_done) begin
                        state <= CHECK;
                    end else if (tmo_hit) begin
                        init_err[ch] <= 1'b1;
                        state        <= NEXT_CH;
                    end
                end
                CHECK: begin
                    if (rd_data != data_in && retry < RW'(MAX_RETRY)) begin
                        retry     <= retry + 1'b1;
                        w_r       <= 1'b1;
                        iic_trig  <= ~busy;
                        tmo_cnt   <= '0;
                        seen_busy <= 1'b0;
                        state     <= WR_TRIG;
                    end else begin
                        if (rd_data != data_in) init_err[ch] <= 1'b1;
                        idx   <= idx + 1'b1;
                        retry <= '0;
                        state <= idx_last ? NEXT_CH : FETCH;
                    end
                end
                DELAY: begin
                    if (dly_cnt + 32'd1 >= dly_tgt) begin
                        idx   <= idx + 1'b1;
                        retry <= '0;
                        state <= idx_last ? NEXT_CH : FETCH;
                    end else begin
                        dly_cnt <= dly_cnt + 32'd1;
                    end
                end
                NEXT_CH: begin
                    init_over[ch] <= 1'b1;
                    idx           <= '0;
                    retry         <= '0;
                    if (ch_last) begin
                        all_done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= FETCH;
                    end
                end
                DONE: begin
                    if (reinit) begin
                        init_over <= '0;
                        init_err  <= '0;
                        all_done  <= 1'b0;
                        ch        <= '0;
                        idx       <= '0;
                        state     <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iic_multi_init.sv
// Bench for iic_multi_init: instance 0 runs without verify, instance 1 with verify; a shared driver model answers both.
`timescale 1ns/1ps
module tb_iic_multi_init;

    localparam int NCH = 2;
    localparam int DEP = 8;
    localparam int NROM = NCH * DEP;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic        sys_rst_n;
    logic        reinit    [2];
    logic [3:0]  tbl_addr  [2];
    logic [31:0] tbl_data  [2];
    logic [0:0]  ch_sel    [2];
    logic [7:0]  device_id [2];
    logic        iic_trig  [2];
    logic        w_r       [2];
    logic [15:0] addr      [2];
    logic [7:0]  data_in   [2];
    logic        busy      [2];
    logic [7:0]  data_out  [2];
    logic        byte_over [2];
    logic [1:0]  init_over [2];
    logic [1:0]  init_err  [2];
    logic        all_done  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        iic_multi_init #(
            .CLK_FREQ(1000), .NUM_CH(NCH), .TBL_DEPTH(DEP),
            .VERIFY(g), .MAX_RETRY(3), .TIMEOUT(100)
        ) u_dut (
            .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .reinit(reinit[g]),
            .tbl_addr(tbl_addr[g]), .tbl_data(tbl_data[g]), .ch_sel(ch_sel[g]),
            .device_id(device_id[g]), .iic_trig(iic_trig[g]), .w_r(w_r[g]),
            .addr(addr[g]), .data_in(data_in[g]), .busy(busy[g]),
            .data_out(data_out[g]), .byte_over(byte_over[g]),
            .init_over(init_over[g]), .init_err(init_err[g]), .all_done(all_done[g])
        );
    end

    logic [31:0] rom [2][NROM];
    always_ff @(posedge sys_clk)
        for (int g = 0; g < 2; g++) tbl_data[g] <= rom[g][tbl_addr[g]];

    // Driver model: 20-cycle busy per trigger, byte_over on read completion, logs every trigger.
    int          cyc = 0;
    int          stuck_at [2];
    int          rd_bad   [2];
    int          trig_cnt [2];
    int          rd_cnt   [2];
    int          bcnt     [2];
    int          err_cyc  [2];
    logic        err_seen [2];
    logic        lat_wr   [2];
    logic [7:0]  lat_dat  [2];
    logic [33:0] txn_log  [2][64];
    int          trig_cyc [2][64];
    logic [1:0]  ovr_log  [2][64];

    always_ff @(posedge sys_clk) cyc <= cyc + 1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int g = 0; g < 2; g++) begin
                busy[g] <= 1'b0; byte_over[g] <= 1'b0; data_out[g] <= 8'h00;
                trig_cnt[g] <= 0; rd_cnt[g] <= 0; bcnt[g] <= 0;
                err_cyc[g] <= 0; err_seen[g] <= 1'b0; lat_wr[g] <= 1'b1; lat_dat[g] <= 8'h00;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                byte_over[g] <= 1'b0;
                if (init_err[g] != 2'b00 && !err_seen[g]) begin
                    err_seen[g] <= 1'b1;
                    err_cyc[g]  <= cyc;
                end
                if (iic_trig[g]) begin
                    if (trig_cnt[g] < 64) begin
                        txn_log[g][trig_cnt[g]]  <= {ch_sel[g], w_r[g], device_id[g], addr[g], data_in[g]};
                        trig_cyc[g][trig_cnt[g]] <= cyc;
                        ovr_log[g][trig_cnt[g]]  <= init_over[g];
                    end
                    trig_cnt[g] <= trig_cnt[g] + 1;
                    lat_wr[g]   <= w_r[g];
                    lat_dat[g]  <= data_in[g];
                    if (trig_cnt[g] != stuck_at[g]) begin
                        busy[g] <= 1'b1;
                        bcnt[g] <= 20;
                    end
                end else if (busy[g]) begin
                    if (bcnt[g] == 1) begin
                        busy[g] <= 1'b0;
                        if (!lat_wr[g]) begin
                            byte_over[g] <= 1'b1;
                            data_out[g]  <= (rd_cnt[g] < rd_bad[g]) ? 8'h00 : lat_dat[g];
                            rd_cnt[g]    <= rd_cnt[g] + 1;
                        end
                    end else begin
                        bcnt[g] <= bcnt[g] - 1;
                    end
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int rel_cyc = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ent(input logic [7:0] d, input logic [15:0] r, input logic [7:0] v);
        return {d, r, v};
    endfunction

    function automatic logic [33:0] tx(input logic c, input logic wr, input logic [7:0] d,
                                       input logic [15:0] a, input logic [7:0] v);
        return {c, wr, d, a, v};
    endfunction

    task automatic clear_rom();
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < NROM; i++) rom[g][i] = 32'hFF00_0000;
    endtask

    task automatic load_basic(input int g);
        rom[g][0] = ent(8'h2B, 16'h0001, 8'h11);
        rom[g][1] = ent(8'h2B, 16'h0002, 8'h22);
        rom[g][2] = ent(8'h2B, 16'h0003, 8'h33);
        rom[g][DEP + 0] = ent(8'h56, 16'h0010, 8'hA1);
        rom[g][DEP + 1] = ent(8'h56, 16'h0011, 8'hA2);
    endtask

    task automatic release_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        rel_cyc   = cyc;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        reinit[0] = 1'b0;
        reinit[1] = 1'b0;
        repeat (3) @(negedge sys_clk);
        release_reset();
    endtask

    task automatic wait_done(input int g, input string tag);
        int n = 0;
        while (!all_done[g] && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        check_val({tag, " all_done"}, 64'(all_done[g]), 64'd1);
    endtask

    task automatic wait_trig(input int g, input int cnt, input string tag);
        int n = 0;
        while (trig_cnt[g] < cnt && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        check_val({tag, " trig reached"}, 64'(trig_cnt[g] >= cnt), 64'd1);
    endtask

    logic [33:0] exp1 [5];

    initial begin
        sys_rst_n = 1'b0;
        reinit[0] = 1'b0;
        reinit[1] = 1'b0;
        stuck_at[0] = 99; stuck_at[1] = 99;
        rd_bad[0] = 0;    rd_bad[1] = 0;
        clear_rom();
        exp1[0] = tx(1'b0, 1'b1, 8'h2B, 16'h0001, 8'h11);
        exp1[1] = tx(1'b0, 1'b1, 8'h2B, 16'h0002, 8'h22);
        exp1[2] = tx(1'b0, 1'b1, 8'h2B, 16'h0003, 8'h33);
        exp1[3] = tx(1'b1, 1'b1, 8'h56, 16'h0010, 8'hA1);
        exp1[4] = tx(1'b1, 1'b1, 8'h56, 16'h0011, 8'hA2);

        // Reset values
        repeat (2) @(negedge sys_clk);
        check_val("rst w_r", 64'(w_r[0]), 64'd1);
        check_val("rst outputs", 64'({iic_trig[0], device_id[0], addr[0], data_in[0], tbl_addr[0],
                                      ch_sel[0], init_over[0], init_err[0], all_done[0]}), 64'd0);

        // Two channels, no verify; a reinit pulse mid-run must be ignored
        load_basic(0);
        do_reset();
        wait_trig(0, 1, "t1");
        reinit[0] = 1'b1;
        @(negedge sys_clk);
        reinit[0] = 1'b0;
        wait_done(0, "t1");
        check_val("t1 trig count", 64'(trig_cnt[0]), 64'd5);
        for (int k = 0; k < 5; k++)
            check_val($sformatf("t1 txn%0d", k), 64'(txn_log[0][k]), 64'(exp1[k]));
        check_val("t1 first trig latency", 64'(trig_cyc[0][0] - rel_cyc), 64'd4);
        // 20 busy cycles + 4 overhead + the trigger cycle itself
        check_val("t1 entry spacing", 64'(trig_cyc[0][1] - trig_cyc[0][0]), 64'd25);
        check_val("t1 over before ch0 end", 64'(ovr_log[0][2]), 64'd0);
        check_val("t1 over at ch1 start", 64'(ovr_log[0][3]), 64'd1);
        check_val("t1 init_over", 64'(init_over[0]), 64'd3);
        check_val("t1 init_err", 64'(init_err[0]), 64'd0);

        // Reinit from DONE clears flags next cycle and reruns everything
        reinit[0] = 1'b1;
        @(negedge sys_clk);
        reinit[0] = 1'b0;
        check_val("reinit flags clear", 64'({init_over[0], init_err[0], all_done[0]}), 64'd0);
        wait_done(0, "reinit");
        check_val("reinit trig count", 64'(trig_cnt[0]), 64'd10);
        check_val("reinit first txn", 64'(txn_log[0][5]), 64'(exp1[0]));
        check_val("reinit init_over", 64'(init_over[0]), 64'd3);

        // Delay entries: 2 ms at 1 tick/ms, then a zero delay
        clear_rom();
        rom[0][0] = ent(8'h2B, 16'h0001, 8'h11);
        rom[0][1] = ent(8'hFE, 16'h1234, 8'h02);
        rom[0][2] = ent(8'h2B, 16'h0002, 8'h22);
        rom[0][3] = ent(8'hFE, 16'h0000, 8'h00);
        rom[0][4] = ent(8'h2B, 16'h0003, 8'h33);
        do_reset();
        wait_done(0, "dly");
        check_val("dly trig count", 64'(trig_cnt[0]), 64'd3);
        // 25 base + 3 (fetch/decode of delay entry) + 2 delay cycles
        check_val("dly 2ms spacing", 64'(trig_cyc[0][1] - trig_cyc[0][0]), 64'd30);
        check_val("dly 0ms spacing", 64'(trig_cyc[0][2] - trig_cyc[0][1]), 64'd28);
        check_val("dly last txn", 64'(txn_log[0][2]), 64'(exp1[2]));

        // Timeout: first trigger never gets busy, ch0 abandoned, ch1 proceeds
        clear_rom();
        rom[0][0]       = ent(8'h2B, 16'h0001, 8'h11);
        rom[0][1]       = ent(8'h2B, 16'h0002, 8'h22);
        rom[0][DEP + 0] = ent(8'h56, 16'h0010, 8'hA1);
        stuck_at[0] = 0;
        do_reset();
        wait_done(0, "tmo");
        check_val("tmo err latency", 64'(err_cyc[0] - trig_cyc[0][0]), 64'd101);
        check_val("tmo init_err", 64'(init_err[0]), 64'd1);
        check_val("tmo trig count", 64'(trig_cnt[0]), 64'd2);
        check_val("tmo ch1 txn", 64'(txn_log[0][1]), 64'(tx(1'b1, 1'b1, 8'h56, 16'h0010, 8'hA1)));
        check_val("tmo init_over", 64'(init_over[0]), 64'd3);
        stuck_at[0] = 99;

        // Verify: two bad read-backs then a good one
        clear_rom();
        rom[1][0] = ent(8'h2B, 16'h0040, 8'h5A);
        rd_bad[1] = 2;
        do_reset();
        wait_done(1, "vfy");
        check_val("vfy trig count", 64'(trig_cnt[1]), 64'd6);
        for (int k = 0; k < 6; k++)
            check_val($sformatf("vfy txn%0d", k), 64'(txn_log[1][k]),
                      64'(tx(1'b0, (k % 2) == 0, 8'h2B, 16'h0040, 8'h5A)));
        check_val("vfy init_err", 64'(init_err[1]), 64'd0);
        check_val("vfy init_over", 64'(init_over[1]), 64'd3);

        // Retries exhausted on entry 0 (1 + 3 attempts), entry 1 still runs and passes
        clear_rom();
        rom[1][0] = ent(8'h2B, 16'h0041, 8'h5A);
        rom[1][1] = ent(8'h2B, 16'h0042, 8'h66);
        rd_bad[1] = 4;
        do_reset();
        wait_done(1, "rty");
        check_val("rty trig count", 64'(trig_cnt[1]), 64'd10);
        check_val("rty last read", 64'(txn_log[1][7]), 64'(tx(1'b0, 1'b0, 8'h2B, 16'h0041, 8'h5A)));
        check_val("rty next entry", 64'(txn_log[1][8]), 64'(tx(1'b0, 1'b1, 8'h2B, 16'h0042, 8'h66)));
        check_val("rty init_err", 64'(init_err[1]), 64'd1);
        check_val("rty init_over", 64'(init_over[1]), 64'd3);
        rd_bad[1] = 0;

        // Asynchronous reset in the middle of a write wait
        clear_rom();
        load_basic(0);
        do_reset();
        wait_trig(0, 2, "arst");
        repeat (5) @(negedge sys_clk);
        check_val("arst pre addr", 64'({device_id[0], addr[0]}), 64'h2B_0002);
        sys_rst_n = 1'b0;
        #1;
        check_val("arst w_r", 64'(w_r[0]), 64'd1);
        check_val("arst outputs", 64'({iic_trig[0], device_id[0], addr[0], data_in[0], tbl_addr[0],
                                       ch_sel[0], init_over[0], init_err[0], all_done[0]}), 64'd0);
        release_reset();
        wait_trig(0, 1, "arst restart");
        check_val("arst restart latency", 64'(trig_cyc[0][0] - rel_cyc), 64'd4);
        check_val("arst restart txn", 64'(txn_log[0][0]), 64'(exp1[0]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
